// File: rtl/sha256_round_ctrl_if.sv
// Handshake and per-round control bundle between the SHA-256 round sequencer,
// the upstream block assembler, the hash datapath and the digest consumer.
interface sha256_round_ctrl_if #(
  parameter int rounds_p = 64
);
  localparam int round_width_lp = $clog2(rounds_p);

  logic                      en_i;
  logic                      v_i;
  logic                      first_i;
  logic                      ready_o;
  logic                      init_hash_o;
  logic                      load_block_o;
  logic [round_width_lp-1:0] round_o;
  logic                      w_sel_o;
  logic                      round_en_o;
  logic                      final_add_o;
  logic                      v_o;
  logic                      yumi_i;
  logic                      busy_o;

  // Environment side: drives enable, block handshake and digest consumption.
  modport master (
    output en_i, v_i, first_i, yumi_i,
    input  ready_o, init_hash_o, load_block_o, round_o, w_sel_o,
           round_en_o, final_add_o, v_o, busy_o
  );

  // Controller side.
  modport slave (
    input  en_i, v_i, first_i, yumi_i,
    output ready_o, init_hash_o, load_block_o, round_o, w_sel_o,
           round_en_o, final_add_o, v_o, busy_o
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression control sequencer: accepts a block, pulses IV/load,
// steps the round counter, pulses the final hash add and presents digest-valid.
module sha256_round_ctrl #(
  parameter int rounds_p = 64
) (
  input logic                  clk_i,
  input logic                  reset_i,
  sha256_round_ctrl_if.slave   bus
);
  localparam int round_width_lp = $clog2(rounds_p);

  localparam logic [round_width_lp-1:0] LastRound  = round_width_lp'(rounds_p - 1);
  localparam logic [round_width_lp-1:0] FirstExpnd = round_width_lp'(16);

  if (rounds_p <= 16 || rounds_p > 64) begin : g_bad_rounds
    $error("sha256_round_ctrl: rounds_p must be >16 and <=64");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state, w_state_n;
  logic [round_width_lp-1:0] r_cnt, w_cnt_n;
  logic                      r_first, w_first_n;
  logic                      r_hv, w_hv_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_hv    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_first <= w_first_n;
      r_hv    <= w_hv_n;
    end
  end

  // Every datapath strobe is qualified by en_i so a frozen cycle neither
  // repeats nor skips an action; round_o/w_sel_o follow the held counter.
  always_comb begin
    w_state_n        = r_state;
    w_cnt_n          = r_cnt;
    w_first_n        = r_first;
    w_hv_n           = r_hv;
    bus.ready_o      = 1'b0;
    bus.init_hash_o  = 1'b0;
    bus.load_block_o = 1'b0;
    bus.round_o      = '0;
    bus.w_sel_o      = 1'b0;
    bus.round_en_o   = 1'b0;
    bus.final_add_o  = 1'b0;
    bus.v_o          = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.ready_o = bus.en_i;
        if (bus.en_i && bus.v_i) begin
          w_first_n = bus.first_i;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.load_block_o = bus.en_i;
        bus.init_hash_o  = bus.en_i & (r_first | ~r_hv);
        if (bus.en_i) begin
          w_cnt_n   = '0;
          w_state_n = S_ROUND;
        end
      end
      S_ROUND: begin
        bus.round_en_o = bus.en_i;
        bus.round_o    = r_cnt;
        bus.w_sel_o    = (r_cnt >= FirstExpnd);
        if (bus.en_i) begin
          if (r_cnt == LastRound) begin
            w_cnt_n   = '0;
            w_state_n = S_FINAL;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      S_FINAL: begin
        bus.final_add_o = bus.en_i;
        if (bus.en_i) begin
          w_hv_n    = 1'b1;
          w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        bus.v_o = bus.en_i;
        if (bus.en_i && bus.yumi_i) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o = (r_state != S_IDLE);

endmodule
